// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle pulse generator.
//   state_t      : debounce FSM state, 2-bit encoding
//   DEF_*        : default parameter values used by toggle_pulse_gen
//   PRESS_CNT_W  : width of the observable press counter
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_EN       = 0;
  localparam int DEF_REPEAT_DELAY    = 8;
  localparam int DEF_REPEAT_PERIOD   = 4;
  localparam int DEF_CNT_W           = 16;
  localparam int PRESS_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock, rising edge
//   reset : synchronous active-high reset, clears both flops to 0
//   d     : asynchronous input level
//   q     : synchronized level, two edges after d is first sampled
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;
  logic meta_d;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner feeding the T input of a T flip-flop.
// Synchronizes a raw bouncy button, debounces it with a 4-state FSM,
// optionally auto-repeats while held, and emits one-cycle toggle pulses.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   btn_in      : raw asynchronous button level
//   enable      : gates pulse emission; the FSM keeps tracking when low
//   t_pulse     : registered one-cycle toggle pulse
//   btn_stable  : registered debounced button level
//   press_count : number of emitted pulses, wraps modulo 256
module toggle_pulse_gen
  import toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_in,
  input  logic                   enable,
  output logic                   t_pulse,
  output logic                   btn_stable,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_FIRE   = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam bit               RPT_ON     = (REPEAT_EN != 0);

  logic btn_sync;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
  logic [CNT_W-1:0]       rpt_inc;
  logic                   evt;
  logic                   t_pulse_q, t_pulse_d;
  logic                   btn_stable_q, btn_stable_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    evt       = 1'b0;
    rpt_inc   = rpt_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_CHK;
          db_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_sync) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = HELD;
          db_cnt_d  = '0;
          rpt_cnt_d = '0;
          evt       = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d   = REL_CHK;
          db_cnt_d  = '0;
          rpt_cnt_d = '0;
        end else if (RPT_ON) begin
          // Fire on the incremented value so the registered pulse lands in
          // the HELD cycle whose count equals REPEAT_DELAY; reloading to
          // DELAY-PERIOD then spaces later pulses exactly PERIOD apart.
          if (rpt_inc == RPT_FIRE) begin
            evt       = 1'b1;
            rpt_cnt_d = RPT_RELOAD;
          end else begin
            rpt_cnt_d = rpt_inc;
          end
        end
      end
      REL_CHK: begin
        if (btn_sync) begin
          // Release bounce: resume holding, repeat delay restarts from 0.
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        db_cnt_d  = '0;
        rpt_cnt_d = '0;
      end
    endcase

    t_pulse_d     = evt & enable;
    btn_stable_d  = (state_d == HELD) || (state_d == REL_CHK);
    press_count_d = press_count_q + PRESS_CNT_W'(t_pulse_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      rpt_cnt_q     <= '0;
      t_pulse_q     <= 1'b0;
      btn_stable_q  <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      rpt_cnt_q     <= rpt_cnt_d;
      t_pulse_q     <= t_pulse_d;
      btn_stable_q  <= btn_stable_d;
      press_count_q <= press_count_d;
    end
  end

  assign t_pulse     = t_pulse_q;
  assign btn_stable  = btn_stable_q;
  assign press_count = press_count_q;

endmodule
